mtl_slide_sequencer: RTL

//   Consumes the one-cycle next_slide_pulse from the MTL display Avalon slave.

---
 rtl/mtl_slide_sequencer.sv | 111 +++++++++++
 1 files changed

// File: rtl/mtl_slide_sequencer.sv
// Slide sequencer: latches a next-slide request and applies it at the next frame
// boundary, then ignores further requests for a fixed number of frames.
module mtl_slide_sequencer #(
    parameter int NUM_SLIDES     = 4,
    parameter int IDX_W          = 2,
    parameter int ADDR_W         = 32,
    parameter int BASE_ADDR      = 0,
    parameter int SLIDE_BYTES    = 1536000,
    parameter int HOLDOFF_FRAMES = 6,
    parameter int HOLD_W         = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              next_slide_pulse,
    input  logic              vsync_start,
    output logic [IDX_W-1:0]  slide_index,
    output logic [ADDR_W-1:0] fb_base_addr,
    output logic              swap_pulse,
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PENDING = 2'd1,
        HOLDOFF = 2'd2
    } state_t;

    localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(NUM_SLIDES - 1);
    localparam logic [ADDR_W-1:0] BASE      = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W-1:0] STRIDE    = ADDR_W'(SLIDE_BYTES);
    localparam logic [HOLD_W-1:0] HOLD_INIT = HOLD_W'(HOLDOFF_FRAMES);

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [HOLD_W-1:0]  hold_q, hold_d;
    logic               swap_q, swap_d;
    logic               busy_q, busy_d;
    logic               wrap;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        addr_d  = addr_q;
        hold_d  = hold_q;
        swap_d  = 1'b0;
        wrap    = (idx_q == LAST_IDX);

        case (state_q)
            IDLE: begin
                // A request coincident with vsync only arms; the swap waits a full frame.
                if (next_slide_pulse) begin
                    state_d = PENDING;
                end
            end
            PENDING: begin
                if (vsync_start) begin
                    idx_d  = wrap ? '0 : idx_q + 1'b1;
                    addr_d = wrap ? BASE : addr_q + STRIDE;
                    swap_d = 1'b1;
                    if (HOLDOFF_FRAMES == 0) begin
                        state_d = IDLE;
                    end else begin
                        state_d = HOLDOFF;
                        hold_d  = HOLD_INIT;
                    end
                end
            end
            HOLDOFF: begin
                if (vsync_start) begin
                    if (hold_q <= 1) begin
                        state_d = IDLE;
                        hold_d  = '0;
                    end else begin
                        hold_d  = hold_q - 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                hold_d  = '0;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            idx_q   <= '0;
            addr_q  <= BASE;
            hold_q  <= '0;
            swap_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            addr_q  <= addr_d;
            hold_q  <= hold_d;
            swap_q  <= swap_d;
            busy_q  <= busy_d;
        end
    end

    assign slide_index  = idx_q;
    assign fb_base_addr = addr_q;
    assign swap_pulse   = swap_q;
    assign busy         = busy_q;

endmodule
